// File: rtl/det_bareiss_engine.sv
// det_bareiss_engine: streamed N x N exact integer determinant by fraction-free (Bareiss) elimination with row-swap pivoting.
//   Params : N (2..8) matrix dimension, DW input element width, OW internal/result width (OW >= DW)
//   Inputs : Clk, Reset (sync, active-high), CEN (clock enable), Start, Ack, in_valid, in_data[DW-1:0] (row-major)
//   Outputs: in_ready (= q_Load), det[OW-1:0], singular, ovf, q_I/q_Load/q_Comp/q_Done (one-hot state)
//   Option : DET_OVF_CHECK_EN enables the sticky out-of-range flag on ovf; undefined ties ovf to 0.
module det_bareiss_engine #(
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int OW = 64
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CEN,
    input  logic          Start,
    input  logic          Ack,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [OW-1:0] det,
    output logic          singular,
    output logic          ovf,
    output logic          q_I,
    output logic          q_Load,
    output logic          q_Comp,
    output logic          q_Done
);
    localparam logic [3:0] S_I = 4'b0001, S_LOAD = 4'b0010, S_COMP = 4'b0100, S_DONE = 4'b1000;
    localparam logic [1:0] P_PIV = 2'd0, P_SCAN = 2'd1, P_UPD = 2'd2;
    localparam logic [2:0] NM1 = 3'(N - 1), NM2 = 3'(N - 2);
    logic [3:0] state_q, state_d;
    logic [1:0] ph_q;
    logic [2:0] lr_q, lc_q, k_q, i_q, j_q;
    logic sign_q, sing_q;
    // Storage is always 8x8 so 3-bit indices address it exactly; rows/cols >= N stay zero.
    logic signed [OW-1:0] a_q [8][8];
    logic signed [OW-1:0] prev_q, det_q, q_lo, f_lo;
    logic signed [2*OW-1:0] w_ij, w_kk, w_ik, w_kj, w_pv, num;
    logic load_last, piv_nz, col_nz, upd_last, sing_exit, comp_end;
`ifdef DET_OVF_CHECK_EN
    logic ovf_q, q_ovf, f_ovf;
    logic signed [2*OW-1:0] quo, fin;
`endif
    always_comb begin
        w_ij = (2*OW)'(a_q[i_q][j_q]);
        w_kk = (2*OW)'(a_q[k_q][k_q]);
        w_ik = (2*OW)'(a_q[i_q][k_q]);
        w_kj = (2*OW)'(a_q[k_q][j_q]);
        w_pv = (2*OW)'(prev_q);
        num  = w_ij * w_kk - w_ik * w_kj;
`ifdef DET_OVF_CHECK_EN
        quo   = num / w_pv;
        fin   = sign_q ? -quo : quo;
        q_lo  = quo[OW-1:0];
        f_lo  = fin[OW-1:0];
        q_ovf = quo != (2*OW)'(q_lo);
        f_ovf = fin != (2*OW)'(f_lo);
`else
        q_lo = OW'(num / w_pv);
        f_lo = sign_q ? -q_lo : q_lo;
`endif
        load_last = in_valid && lr_q == NM1 && lc_q == NM1;
        piv_nz    = a_q[k_q][k_q] != '0;
        col_nz    = a_q[i_q][k_q] != '0;
        upd_last  = ph_q == P_UPD && i_q == NM1 && j_q == NM1;
        sing_exit = ph_q == P_SCAN && !col_nz && i_q == NM1;
        comp_end  = upd_last && k_q == NM2;
    end
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_I;
        else if (CEN) state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q[0] && Start)                     ? S_LOAD :
                  (state_q[1] && load_last)                 ? S_COMP :
                  (state_q[2] && (sing_exit || comp_end))   ? S_DONE :
                  (state_q[3] && Ack)                       ? S_I    : state_q;
    end
    always_comb begin
        q_I      = state_q[0];
        q_Load   = state_q[1];
        q_Comp   = state_q[2];
        q_Done   = state_q[3];
        in_ready = state_q[1];
        det      = det_q;
        singular = sing_q;
`ifdef DET_OVF_CHECK_EN
        ovf      = ovf_q;
`else
        ovf      = 1'b0;
`endif
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) a_q[r][c] <= '0;
            {ph_q, lr_q, lc_q, k_q, i_q, j_q, sign_q, sing_q} <= '0;
            det_q  <= '0;
            prev_q <= OW'(1);
`ifdef DET_OVF_CHECK_EN
            ovf_q  <= 1'b0;
`endif
        end else if (CEN) begin
            if (state_q[0] && Start) begin
                {lr_q, lc_q, sign_q, sing_q} <= '0;
                det_q  <= '0;
                prev_q <= OW'(1);
`ifdef DET_OVF_CHECK_EN
                ovf_q  <= 1'b0;
`endif
            end
            if (state_q[1] && in_valid) begin
                a_q[lr_q][lc_q] <= OW'($signed(in_data));
                lc_q <= lc_q == NM1 ? 3'd0 : lc_q + 3'd1;
                lr_q <= lc_q == NM1 ? lr_q + 3'd1 : lr_q;
                if (load_last) begin
                    k_q  <= 3'd0;
                    ph_q <= P_PIV;
                end
            end
            if (state_q[2]) begin
                case (ph_q)
                    P_PIV: begin
                        ph_q <= piv_nz ? P_UPD : P_SCAN;
                        i_q  <= k_q + 3'd1;
                        j_q  <= k_q + 3'd1;
                    end
                    P_SCAN: begin
                        if (col_nz) begin
                            // Whole-row swap; columns < k are already eliminated history and swap harmlessly.
                            for (int c = 0; c < 8; c++) begin
                                a_q[k_q][c] <= a_q[i_q][c];
                                a_q[i_q][c] <= a_q[k_q][c];
                            end
                            sign_q <= ~sign_q;
                            ph_q   <= P_UPD;
                            i_q    <= k_q + 3'd1;
                            j_q    <= k_q + 3'd1;
                        end else if (i_q == NM1) begin
                            det_q  <= '0;
                            sing_q <= 1'b1;
                        end else i_q <= i_q + 3'd1;
                    end
                    default: begin
                        a_q[i_q][j_q] <= q_lo;
`ifdef DET_OVF_CHECK_EN
                        ovf_q <= ovf_q | q_ovf | (comp_end & f_ovf);
`endif
                        j_q <= j_q == NM1 ? k_q + 3'd1 : j_q + 3'd1;
                        if (j_q == NM1) i_q <= i_q + 3'd1;
                        if (upd_last) begin
                            prev_q <= a_q[k_q][k_q];
                            k_q    <= k_q + 3'd1;
                            ph_q   <= P_PIV;
                        end
                        // The final step's single update is a[N-1][N-1], so det takes the fresh quotient.
                        if (comp_end) det_q <= f_lo;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_det_bareiss_engine.sv
// tb_det_bareiss_engine: table-driven self-checking bench for det_bareiss_engine (N=3/OW=64 and N=2/OW=24 instances).
module tb_det_bareiss_engine;
`ifdef DET_OVF_CHECK_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif
    typedef struct {
        bit longint_pad;
        bit s;
        int n;
        int e[9];
        longint d;
        bit sg;
        bit ov;
        int cc;
    } vec_t;
    logic Clk = 1'b0, Reset = 1'b1, CEN = 1'b1, st = 1'b0, ak = 1'b0, vld = 1'b0, sel = 1'b0, tog = 1'b0;
    logic [15:0] dat = '0;
    logic r3, s3, o3, i3, l3, c3, d3, r2, s2, o2, i2, l2, c2, d2;
    logic [63:0] det3;
    logic [23:0] det2;
    logic [63:0] det_m;
    logic sg_m, ov_m, i_m, l_m, c_m, dn_m, rdy_m;
    int checks = 0, errors = 0;
    vec_t tv[8];
    always #5 Clk = ~Clk;
    det_bareiss_engine #(.N(3), .DW(16), .OW(64)) dut3 (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(st & ~sel), .Ack(ak & ~sel),
        .in_valid(vld & ~sel), .in_data(dat), .in_ready(r3), .det(det3), .singular(s3),
        .ovf(o3), .q_I(i3), .q_Load(l3), .q_Comp(c3), .q_Done(d3)
    );
    det_bareiss_engine #(.N(2), .DW(16), .OW(24)) dut2 (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(st & sel), .Ack(ak & sel),
        .in_valid(vld & sel), .in_data(dat), .in_ready(r2), .det(det2), .singular(s2),
        .ovf(o2), .q_I(i2), .q_Load(l2), .q_Comp(c2), .q_Done(d2)
    );
    assign det_m = sel ? 64'($signed(det2)) : det3;
    assign {sg_m, ov_m, i_m, l_m, c_m, dn_m, rdy_m} = sel ? {s2, o2, i2, l2, c2, d2, r2} : {s3, o3, i3, l3, c3, d3, r3};
    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic cyc();
        if (tog) begin
            CEN = 1'b0;
            @(posedge Clk); #1;
        end
        CEN = 1'b1;
        @(posedge Clk); #1;
    endtask
    task automatic load(input int t, input int n, input int e[9], input bit gap);
        st = 1'b1; cyc(); st = 1'b0;
        chk($sformatf("t%0d_load_state", t), l_m, 1);
        chk($sformatf("t%0d_in_ready", t), rdy_m, 1);
        for (int x = 0; x < n; x++) begin
            if (gap && x % 3 == 1) begin
                vld = 1'b0; cyc();
            end
            vld = 1'b1; dat = 16'(e[x]); cyc();
        end
        vld = 1'b0;
    endtask
    task automatic run(input int t, input vec_t v, input bit gap);
        int c = 0;
        sel = v.s;
        load(t, v.n, v.e, gap);
        while (c_m === 1'b1 && c < 400) begin
            cyc(); c++;
        end
        chk($sformatf("t%0d_comp_cycles", t), c, v.cc);
        chk($sformatf("t%0d_done", t), dn_m, 1);
        chk($sformatf("t%0d_det", t), det_m, v.d);
        chk($sformatf("t%0d_singular", t), sg_m, v.sg);
        chk($sformatf("t%0d_ovf", t), ov_m, v.ov);
        cyc();
        chk($sformatf("t%0d_done_hold", t), dn_m, 1);
        ak = 1'b1; cyc(); ak = 1'b0;
        chk($sformatf("t%0d_idle_after_ack", t), i_m, 1);
        chk($sformatf("t%0d_det_kept", t), det_m, v.d);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        tv[0] = '{1'b0, 1'b0, 9, '{2, 1, 3, 0, 4, 1, 5, 2, 0}, -59, 1'b0, 1'b0, 7};
        tv[1] = '{1'b0, 1'b1, 4, '{0, 1, 1, 0, 0, 0, 0, 0, 0}, -1, 1'b0, 1'b0, 3};
        tv[2] = '{1'b0, 1'b0, 9, '{1, 1, 1, 1, 1, 1, 1, 1, 1}, 0, 1'b1, 1'b0, 7};
        tv[3] = '{1'b0, 1'b1, 4, '{32767, -32768, 32767, 32767, 0, 0, 0, 0, 0}, -98303, 1'b0, OVF_EXP, 2};
        tv[4] = '{1'b0, 1'b0, 9, '{1, 0, 0, 0, 1, 0, 0, 0, 1}, 1, 1'b0, 1'b0, 7};
        tv[5] = '{1'b0, 1'b0, 9, '{0, 2, 1, 3, 4, 5, 6, 7, 8}, 9, 1'b0, 1'b0, 8};
        tv[6] = '{1'b0, 1'b1, 4, '{3, -7, 2, 5, 0, 0, 0, 0, 0}, 29, 1'b0, 1'b0, 2};
        tv[7] = '{1'b0, 1'b0, 9, '{1, 2, 3, 2, 4, 6, 1, 1, 1}, 0, 1'b0, 1'b0, 8};
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst_q_I", i3, 1);
        chk("rst_q_Load", l3, 0);
        chk("rst_q_Comp", c3, 0);
        chk("rst_q_Done", d3, 0);
        chk("rst_in_ready", r3, 0);
        chk("rst_det", det3, 0);
        chk("rst_singular", s3, 0);
        chk("rst_ovf", o3, 0);
        chk("rst_det_n2", 64'($signed(det2)), 0);
        for (int t = 0; t < 8; t++) run(t, tv[t], 1'b0);
        tog = 1'b1;
        run(8, tv[0], 1'b1);
        tog = 1'b0;
        sel = 1'b0;
        ak = 1'b1;
        cyc();
        chk("ack_in_I_ignored", i3, 1);
        load(9, 9, tv[0].e, 1'b0);
        chk("ack_in_load_ignored", c3, 1);
        cyc(); cyc();
        chk("ack_in_comp_ignored", c3, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("midcomp_rst_q_I", i3, 1);
        chk("midcomp_rst_q_Comp", c3, 0);
        chk("midcomp_rst_det", det3, 0);
        ak = 1'b0;
        run(10, tv[0], 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/det_bareiss_engine.md
# det_bareiss_engine

Parametrised successor to the fixed 8x8 cofactor determinant unit. Computes the exact signed integer determinant of an N x N matrix using fraction-free (Bareiss) elimination with row-swap pivoting, one element update per enabled cycle. The matrix is streamed in row-major order instead of presented on a wide array port. It keeps the existing I/LOAD/COMP/DONE one-hot state outputs and the Start/Ack handshake, so it drops into the same control wrapper.

## Interface
- N, 8: matrix dimension, legal 2..8
- DW, 16: signed input element width
- OW, 64: signed internal element and result width, OW >= DW
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; overrides CEN
- CEN  in  1  clock enable; when 0, all state holds
- Start  in  1  begin a new computation; sampled only in I
- Ack  in  1  result consumed; sampled only in DONE
- in_valid  in  1  element strobe during LOAD
- in_data  in  DW  signed element, row-major (a[0][0], a[0][1], ...)
- in_ready  out  1  equals q_Load
- det  out  OW  signed determinant; valid while q_Done=1
- singular  out  1  zero column found during pivot search; valid in DONE
- ovf  out  1  sticky intermediate overflow; valid in DONE
- q_I, q_Load, q_Comp, q_Done  out  1 each  one-hot state

## Operation
- Reset: state=I, det=0, singular=0, ovf=0, in_ready=0, internal matrix and counters cleared.
- I: on Start=1, go to LOAD and clear det, singular, ovf, the load counter, sign=+1, and prev=1.
- LOAD: each cycle with in_valid=1, sign-extend in_data to OW and store it at the next row-major position. After element N*N-1 is accepted, go to COMP with k=0. in_valid=0 inserts a stall with no effect.
- COMP, step k = 0..N-2:
  - Pivot cycle: if a[k][k] != 0, proceed to the updates.
  - If a[k][k] == 0, scan rows i=k+1..N-1, one row per cycle. At the first row with a[i][k] != 0, swap rows k and i in that same cycle and negate sign, then proceed to the updates.
  - If no nonzero entry exists, set det=0 and singular=1, and go to DONE.
  - Updates: for i,j in k+1..N-1, in row-major order, one per cycle, a[i][j] <= (a[i][j]*a[k][k] - a[i][k]*a[k][j]) / prev.
    - Products and difference are computed at 2*OW width.
    - The division is exact, signed, and truncating.
    - Row k and column k are not written during step k.
  - After the last update: prev <= a[k][k], k <= k+1.
- After step N-2 completes, det <= sign * a[N-1][N-1] and go to DONE.
- DONE: outputs hold. On Ack=1, go to I; det, singular, and ovf remain valid until the next Start.
- Start outside I and Ack outside DONE are ignored. in_valid outside LOAD is ignored.
- Reset asserted in any state, on any edge, aborts the computation and restores reset values.

## Timing
- All transitions occur on a rising Clk edge with CEN=1; CEN=0 cycles are not counted.
- I to LOAD: 1 cycle after Start.
- LOAD: exactly N*N cycles with in_valid held at 1.
- COMP without swaps: sum over k of (1 + (N-1-k)^2) cycles.
  - N=2: 2 cycles. N=3: 7 cycles. N=8: 147 cycles.
- Each zero-pivot row scanned adds 1 cycle to COMP. The swap itself adds none.
- Singular exit: DONE follows the cycle in which the final row is scanned.
- q_Done asserts the cycle after the last COMP cycle.
- DONE to I: 1 cycle after Ack.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DET_OVF_CHECK_EN defined:
  - ovf is set when any quotient written to a[i][j], or the final sign-applied det, falls outside the signed OW range.
  - On overflow the stored value is the truncated low OW bits, and computation continues.
- DET_OVF_CHECK_EN undefined: ovf is tied to 0 and the range-check logic is omitted.

## Test plan
- N=3, DW=16, OW=64; load 2,1,3,0,4,1,5,2,0 -> q_Comp for exactly 7 cycles, then det=-59, singular=0, ovf=0.
- N=2; load 0,1,1,0 -> zero pivot, row swap, det=-1, singular=0.
- N=3; load all ones -> singular=1, det=0, DONE reached before all updates are performed.
- N=2, DW=16, OW=24, DET_OVF_CHECK_EN defined; load 32767,-32768,32767,32767 -> ovf=1. Same stimulus with the macro undefined -> ovf=0.
- N=3 with CEN toggling every other cycle and in_valid gaps -> same det=-59 as the first scenario; cycle counts match when only CEN=1 cycles are counted.
- Reset pulse mid-COMP -> next cycle q_I=1 and det=0. A following Start and full reload yields the correct det. Ack held high while the block is in I, LOAD, or COMP is ignored.
